// File: rtl/sync_tx_arbiter.sv
// sync_tx_arbiter: round-robin scheduler sharing one bus-enable synchronizer
// crossing between NUM_REQ source-domain requesters.
//
// Ports:
//   CLK         source-domain clock
//   RST         asynchronous active-low reset
//   req         level request per requester, held until its gnt pulse
//   req_data    flattened words, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//   gnt         one-hot, one-cycle pulse when a word is captured
//   done        one-cycle pulse when the gap ends and the slot is free
//   busy        high whenever a transfer (hold or gap) is in progress
//   Unsync_bus  registered data toward the destination synchronizer
//   bus_enable  registered enable toward the destination synchronizer
//   Unsync_src  winner index, present only with SYNC_TX_ARB_SRC_ID_EN
//
// Optional feature macro: SYNC_TX_ARB_SRC_ID_EN
module sync_tx_arbiter #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_REQ     = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           done,
    output logic                           busy,
    output logic [BUS_WIDTH-1:0]           Unsync_bus,
`ifdef SYNC_TX_ARB_SRC_ID_EN
    output logic [$clog2(NUM_REQ)-1:0]     Unsync_src,
`endif
    output logic                           bus_enable
);

    localparam int PW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);

    logic [1:0]           r_state;
    logic [7:0]           r_cnt;
    logic [PW-1:0]        r_ptr;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_done;
    logic [BUS_WIDTH-1:0] r_bus;
    logic                 r_en;
`ifdef SYNC_TX_ARB_SRC_ID_EN
    logic [PW-1:0]        r_src;
`endif

    logic                 w_any;
    logic                 w_found;
    logic [PW:0]          w_cand;
    logic [PW-1:0]        w_win;
    logic [PW-1:0]        w_next_ptr;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [BUS_WIDTH-1:0] w_data;

    assign w_any = |req;

    // Scan upward from the pointer with wrap; the first set bit wins.
    // w_cand is one bit wider so ptr+k never overflows before the wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_cand >= (PW+1)'(NUM_REQ)) begin
                w_cand = w_cand - (PW+1)'(NUM_REQ);
            end
            if (!w_found && req[w_cand[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[PW-1:0];
            end
        end
    end

    assign w_next_ptr = (w_win == PW'(NUM_REQ - 1)) ? '0
                                                     : w_win + PW'(1);

    assign w_data = req_data[int'(w_win)*BUS_WIDTH +: BUS_WIDTH];

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_win] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_done  <= 1'b0;
            r_bus   <= '0;
            r_en    <= 1'b0;
`ifdef SYNC_TX_ARB_SRC_ID_EN
            r_src   <= '0;
`endif
        end else begin
            // gnt and done are single-cycle pulses.
            r_gnt  <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_bus   <= w_data;
                        r_en    <= 1'b1;
                        r_gnt   <= w_onehot;
                        r_ptr   <= w_next_ptr;
                        r_cnt   <= HOLD_LD;
                        r_state <= S_HOLD;
`ifdef SYNC_TX_ARB_SRC_ID_EN
                        r_src   <= w_win;
`endif
                    end
                end
                S_HOLD: begin
                    if (r_cnt == 8'd0) begin
                        r_en    <= 1'b0;
                        r_cnt   <= GAP_LD;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 8'd0) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign busy       = (r_state != S_IDLE);
    assign Unsync_bus = r_bus;
    assign bus_enable = r_en;
`ifdef SYNC_TX_ARB_SRC_ID_EN
    assign Unsync_src = r_src;
`endif

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// tb_sync_tx_arbiter: directed bench for sync_tx_arbiter with a
// transfer-timeline model; unit a = hold 4/gap 4, unit b = hold 1/gap 1.
module tb_sync_tx_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] req_data = 16'h0000;

    logic [1:0]  gnt_a, gnt_b;
    logic        done_a, done_b, busy_a, busy_b, en_a, en_b;
    logic [7:0]  bus_a, bus_b;
`ifdef SYNC_TX_ARB_SRC_ID_EN
    logic        src_a, src_b;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    sync_tx_arbiter #(.BUS_WIDTH(8), .NUM_REQ(2),
                      .HOLD_CYCLES(4), .GAP_CYCLES(4)) u_a (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt_a),
        .done       (done_a),
        .busy       (busy_a),
        .Unsync_bus (bus_a),
`ifdef SYNC_TX_ARB_SRC_ID_EN
        .Unsync_src (src_a),
`endif
        .bus_enable (en_a)
    );

    sync_tx_arbiter #(.BUS_WIDTH(8), .NUM_REQ(2),
                      .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_b (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt_b),
        .done       (done_b),
        .busy       (busy_b),
        .Unsync_bus (bus_b),
`ifdef SYNC_TX_ARB_SRC_ID_EN
        .Unsync_src (src_b),
`endif
        .bus_enable (en_b)
    );

    // Model: a transfer is a timeline of H+G+1 edges counted from the grant
    // edge; enable is high while elapsed < H, done fires at elapsed == H+G.
    int         H[2] = '{4, 1};
    int         G[2] = '{4, 1};
    logic       m_busy[2] = '{1'b0, 1'b0};
    int         m_k[2]    = '{0, 0};
    int         m_ptr[2]  = '{0, 0};
    logic [1:0] m_gnt[2]  = '{2'b00, 2'b00};
    logic       m_done[2] = '{1'b0, 1'b0};
    logic       m_en[2]   = '{1'b0, 1'b0};
    logic [7:0] m_bus[2]  = '{8'h00, 8'h00};
    int         m_src[2]  = '{0, 0};
    int         w_m;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int u = 0; u < 2; u++) begin
                m_busy[u] = 1'b0; m_k[u] = 0; m_ptr[u] = 0;
                m_gnt[u] = 2'b00; m_done[u] = 1'b0;
                m_en[u] = 1'b0; m_bus[u] = 8'h00; m_src[u] = 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                m_gnt[u]  = 2'b00;
                m_done[u] = 1'b0;
                if (!m_busy[u]) begin
                    if (req != 2'b00) begin
                        w_m = -1;
                        for (int j = 0; j < 2; j++)
                            if (w_m < 0 && req[(m_ptr[u] + j) % 2])
                                w_m = (m_ptr[u] + j) % 2;
                        m_bus[u]  = req_data[w_m*8 +: 8];
                        m_gnt[u]  = 2'(1 << w_m);
                        m_src[u]  = w_m;
                        m_ptr[u]  = (w_m + 1) % 2;
                        m_en[u]   = 1'b1;
                        m_k[u]    = 0;
                        m_busy[u] = 1'b1;
                    end
                end else begin
                    m_k[u]  = m_k[u] + 1;
                    m_en[u] = (m_k[u] < H[u]);
                    if (m_k[u] == H[u] + G[u]) begin
                        m_done[u] = 1'b1;
                        m_busy[u] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_u(input string t, input int u, input logic [1:0] g,
                         input logic d, input logic b, input logic [7:0] bs,
                         input logic e);
        chk({t, "_gnt"},  32'(g),  32'(m_gnt[u]));
        chk({t, "_done"}, 32'(d),  32'(m_done[u]));
        chk({t, "_busy"}, 32'(b),  32'(m_busy[u]));
        chk({t, "_bus"},  32'(bs), 32'(m_bus[u]));
        chk({t, "_en"},   32'(e),  32'(m_en[u]));
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        chk_u("a", 0, gnt_a, done_a, busy_a, bus_a, en_a);
        chk_u("b", 1, gnt_b, done_b, busy_b, bus_b, en_b);
`ifdef SYNC_TX_ARB_SRC_ID_EN
        chk("a_src", 32'(src_a), 32'(m_src[0]));
        chk("b_src", 32'(src_b), 32'(m_src[1]));
`endif
    end

    logic [7:0] glog_bus[$];
    int         glog_t[$];

    always @(negedge CLK) begin
        if (RST && gnt_a != 2'b00) begin
            glog_bus.push_back(bus_a);
            glog_t.push_back(cyc);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || busy_b) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_timeout", 32'(n < 40), 32'd1);
    endtask

    task automatic wait_gnt_a();
        int n = 0;
        while (gnt_a == 2'b00 && n < 30) begin
            @(negedge CLK);
            n++;
        end
        chk("gnt_a_timeout", 32'(n < 30), 32'd1);
    endtask

    initial begin
        int n, hi, lo, early;

        // reset values with requests pending
        #1 RST = 1'b0;
        req = 2'b11;
        req_data = {8'h22, 8'h11};
        repeat (3) @(negedge CLK);
        chk("rst_gnt",  32'(gnt_a),  32'h0);
        chk("rst_en",   32'(en_a),   32'h0);
        chk("rst_bus",  32'(bus_a),  32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("first_gnt", 32'(gnt_a), 32'h1);
        chk("first_bus", 32'(bus_a), 32'h11);
        chk("model_first_gnt", 32'(m_gnt[0]), 32'h1);
        chk("model_first_ptr", 32'(m_ptr[0]), 32'h1);

        // fairness: four grants alternating, 9 cycles apart
        repeat (40) @(negedge CLK);
        chk("fair_count", 32'(glog_bus.size() >= 4), 32'd1);
        if (glog_bus.size() >= 4) begin
            chk("fair_bus0", 32'(glog_bus[0]), 32'h11);
            chk("fair_bus1", 32'(glog_bus[1]), 32'h22);
            chk("fair_bus2", 32'(glog_bus[2]), 32'h11);
            chk("fair_bus3", 32'(glog_bus[3]), 32'h22);
            for (int i = 1; i < 4; i++)
                chk("fair_space", 32'(glog_t[i] - glog_t[i-1]), 32'd9);
        end

        // minimum timing on unit b with req[0] constantly high
        req = 2'b01;
        @(negedge CLK);
        n = 0;
        while (gnt_b != 2'b01 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("min_timeout", 32'(n < 10), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("min_en",  32'(en_b),  32'((i % 3) == 0));
            chk("min_gnt", 32'(gnt_b), ((i % 3) == 0) ? 32'h1 : 32'h0);
            @(negedge CLK);
        end
        req = 2'b00;
        wait_idle();

        // single transfer from requester 1
        req_data = {8'hA5, 8'h11};
        req = 2'b10;
        wait_gnt_a();
        chk("single_gnt", 32'(gnt_a), 32'h2);
        chk("single_bus", 32'(bus_a), 32'hA5);
        req = 2'b00;
        hi = 0; lo = 0; n = 0;
        while (!done_a && n < 30) begin
            if (en_a) hi++; else lo++;
            @(negedge CLK);
            n++;
        end
        chk("single_timeout", 32'(n < 30), 32'd1);
        chk("single_hi", 32'(hi), 32'd4);
        chk("single_lo", 32'(lo), 32'd4);
        chk("single_busy_at_done", 32'(busy_a), 32'h0);
        @(negedge CLK);
        chk("single_done_pulse", 32'(done_a), 32'h0);
        wait_idle();

        // reset in the second hold cycle after a grant to requester 0
        req = 2'b01;
        wait_gnt_a();
        req = 2'b00;
        @(posedge CLK);
        #1;
        chk("mid_en_before", 32'(en_a), 32'h1);
        #1 RST = 1'b0;
        #1;
        chk("mid_en_async", 32'(en_a), 32'h0);
        chk("mid_busy", 32'(busy_a), 32'h0);
        repeat (2) @(negedge CLK);
        req = 2'b11;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("ptr_restart_gnt", 32'(gnt_a), 32'h1);
        @(negedge CLK);
        req = 2'b00;
        wait_idle();

        // late request raised during the gap of a requester-1 transfer
        req_data = {8'hA5, 8'h11};
        req = 2'b10;
        wait_gnt_a();
        chk("late_first_gnt", 32'(gnt_a), 32'h2);
        req = 2'b00;
        n = 0;
        while (en_a && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("late_gap_timeout", 32'(n < 10), 32'd1);
        req = 2'b01;
        early = 0; n = 0;
        while (!done_a && n < 20) begin
            if (gnt_a != 2'b00) early++;
            @(negedge CLK);
            n++;
        end
        chk("late_done_timeout", 32'(n < 20), 32'd1);
        chk("late_no_early_gnt", 32'(early), 32'd0);
        @(negedge CLK);
        chk("late_gnt", 32'(gnt_a), 32'h1);
        chk("late_bus", 32'(bus_a), 32'h11);
`ifdef SYNC_TX_ARB_SRC_ID_EN
        chk("late_src", 32'(src_a), 32'h0);
`endif
        req = 2'b00;
        wait_idle();
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
